// File: rtl/fwd_scoreboard_if.sv
// rtl/fwd_scoreboard_if.sv - decode-stage handshake bundle for the forwarding scoreboard
interface fwd_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4,
  parameter int REG_W   = 5,
  parameter int LAT_W   = 3,
  parameter int FSEL_W  = $clog2(DEPTH + 1)
);
  logic                      issue_valid;
  logic [NUM_SRC*REG_W-1:0]  src_reg;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_late;
  logic [REG_W-1:0]          dst_reg;
  logic                      dst_valid;
  logic [LAT_W-1:0]          dst_lat;
  logic                      hold;
  logic                      flush;
  logic                      issue_fire;
  logic                      stall;
  logic [NUM_SRC*FSEL_W-1:0] fwd_sel;
  logic [FSEL_W-1:0]         inflight;

  // Decode side: presents instructions, consumes stall/forward decisions
  modport master (
    output issue_valid, src_reg, src_valid, src_late, dst_reg, dst_valid, dst_lat, hold, flush,
    input  issue_fire, stall, fwd_sel, inflight
  );

  // Scoreboard side
  modport slave (
    input  issue_valid, src_reg, src_valid, src_late, dst_reg, dst_valid, dst_lat, hold, flush,
    output issue_fire, stall, fwd_sel, inflight
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - DEPTH-entry in-flight hazard/forwarding scoreboard
module fwd_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4,
  parameter int REG_W   = 5,
  parameter int LAT_W   = 3,
  parameter int FSEL_W  = $clog2(DEPTH + 1)
) (
  input  logic         i_clock,
  input  logic         i_reset,
  fwd_scoreboard_if.slave bus
);
  localparam logic [LAT_W-1:0] LAT_DEPTH = LAT_W'(DEPTH);

  // Index k holds pipeline stage k+1 (index 0 = EX)
  logic [DEPTH-1:0]     r_vld;
  logic [REG_W-1:0]     r_reg [DEPTH];
  logic [LAT_W-1:0]     r_rem [DEPTH];
  logic [FSEL_W-1:0]    r_inflight;

  logic [NUM_SRC*FSEL_W-1:0] w_sel;
  logic [NUM_SRC-1:0]        w_haz;
  logic                      w_stall;
  logic                      w_fire;
  logic [LAT_W-1:0]          w_rem1;
  logic [DEPTH-1:0]          w_vld_nxt;
  logic [REG_W-1:0]          w_reg_nxt [DEPTH];
  logic [LAT_W-1:0]          w_rem_nxt [DEPTH];
  logic [FSEL_W-1:0]         w_cnt;

  // Per-operand match; scanning oldest to youngest so the youngest match is left standing
  always_comb begin
    w_sel = '0;
    w_haz = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (bus.src_valid[i] && r_vld[k] &&
            r_reg[k] == bus.src_reg[i*REG_W +: REG_W] &&
            bus.src_reg[i*REG_W +: REG_W] != '0) begin
          w_sel[i*FSEL_W +: FSEL_W] = FSEL_W'(k + 1);
          w_haz[i] = r_rem[k] > (bus.src_late[i] ? LAT_W'(1) : LAT_W'(0));
        end
      end
    end
  end

  assign w_stall = ~i_reset & bus.issue_valid & (|w_haz);
  assign w_fire  = ~i_reset & bus.issue_valid & ~w_stall & ~bus.hold & ~bus.flush;

  // Remaining latency at stage 1: latency clamped to [1, DEPTH], minus the cycle spent entering
  always_comb begin
    w_rem1 = bus.dst_lat - LAT_W'(1);
    if (bus.dst_lat == '0) begin
      w_rem1 = '0;
    end else if (bus.dst_lat > LAT_DEPTH) begin
      w_rem1 = LAT_DEPTH - LAT_W'(1);
    end
  end

  // Next-state of the in-flight shift register: flush clears, hold freezes, else advance
  always_comb begin
    w_vld_nxt = r_vld;
    w_reg_nxt = r_reg;
    w_rem_nxt = r_rem;
    if (bus.flush) begin
      w_vld_nxt = '0;
    end else if (!bus.hold) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        w_vld_nxt[k] = r_vld[k-1];
        w_reg_nxt[k] = r_reg[k-1];
        w_rem_nxt[k] = (r_rem[k-1] == '0) ? '0 : r_rem[k-1] - LAT_W'(1);
      end
      w_vld_nxt[0] = w_fire & bus.dst_valid & (bus.dst_reg != '0);
      w_reg_nxt[0] = bus.dst_reg;
      w_rem_nxt[0] = w_rem1;
    end
  end

  // Population count of the next valid vector feeds the registered inflight count
  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_cnt = w_cnt + FSEL_W'(w_vld_nxt[k]);
    end
  end

  // State update with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_vld      <= '0;
      r_inflight <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_reg[k] <= '0;
        r_rem[k] <= '0;
      end
    end else begin
      r_vld      <= w_vld_nxt;
      r_reg      <= w_reg_nxt;
      r_rem      <= w_rem_nxt;
      r_inflight <= w_cnt;
    end
  end

  assign bus.issue_fire = w_fire;
  assign bus.stall      = w_stall;
  assign bus.fwd_sel    = i_reset ? '0 : w_sel;
  assign bus.inflight   = r_inflight;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed self-checking bench for fwd_scoreboard
module tb_fwd_scoreboard;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 4;
  localparam int REG_W   = 5;
  localparam int LAT_W   = 3;
  localparam int FSEL_W  = $clog2(DEPTH + 1);

  logic clk;
  logic rst;
  int   n_pass;
  int   n_fail;
  int   n_total;

  fwd_scoreboard_if #(
    .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .REG_W(REG_W), .LAT_W(LAT_W), .FSEL_W(FSEL_W)
  ) sb_if ();

  fwd_scoreboard #(
    .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .REG_W(REG_W), .LAT_W(LAT_W), .FSEL_W(FSEL_W)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [FSEL_W-1:0] fsel(input int i);
    return sb_if.fwd_sel[i*FSEL_W +: FSEL_W];
  endfunction

  task automatic drive(input logic iv, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] sv, input logic [1:0] sl, input logic [4:0] dr,
                       input logic dv, input logic [2:0] dl, input logic h, input logic f);
    sb_if.issue_valid = iv;
    sb_if.src_reg     = {s1, s0};
    sb_if.src_valid   = sv;
    sb_if.src_late    = sl;
    sb_if.dst_reg     = dr;
    sb_if.dst_valid   = dv;
    sb_if.dst_lat     = dl;
    sb_if.hold        = h;
    sb_if.flush       = f;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] dr, input logic [2:0] dl);
    drive(1, 0, 0, 0, 0, dr, 1, dl, 0, 0);
    tick();
  endtask

  task automatic drain();
    repeat (DEPTH + 1) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    n_pass = 0;
    n_fail = 0;
    n_total = 0;
    rst = 1'b1;
    drive(1, 5, 5, 2'b11, 0, 5, 1, 1, 0, 0);
    tick();

    // Reset held two cycles with an instruction presented
    repeat (2) begin
      drive(1, 5, 5, 2'b11, 0, 5, 1, 1, 0, 0);
      chk("rst_stall", sb_if.stall, 0);
      chk("rst_fwd", sb_if.fwd_sel, 0);
      chk("rst_fire", sb_if.issue_fire, 0);
      tick();
      chk("rst_inflight", sb_if.inflight, 0);
    end
    rst = 1'b0;

    // ALU back-to-back
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    chk("alu_fire", sb_if.issue_fire, 1);
    tick();
    chk("alu_inflight", sb_if.inflight, 1);
    drive(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    chk("alu_stall", sb_if.stall, 0);
    chk("alu_fsel0", fsel(0), 1);
    tick();
    drive(1, 0, 5, 2'b10, 0, 0, 0, 0, 0, 0);
    chk("alu_stall2", sb_if.stall, 0);
    chk("alu_fsel1", fsel(1), 2);
    tick();
    drain();
    chk("drain_inflight", sb_if.inflight, 0);

    // Load-use: one bubble, then forwarded from stage 2
    issue(8, 2);
    drive(1, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    chk("ld_stall", sb_if.stall, 1);
    chk("ld_nofire", sb_if.issue_fire, 0);
    tick();
    drive(1, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    chk("ld_stall_end", sb_if.stall, 0);
    chk("ld_fsel0", fsel(0), 2);
    chk("ld_fire", sb_if.issue_fire, 1);
    tick();
    drain();

    // Load feeding late-needed store data
    issue(8, 2);
    drive(1, 0, 8, 2'b10, 2'b10, 0, 0, 0, 0, 0);
    chk("late_stall", sb_if.stall, 0);
    chk("late_fsel1", fsel(1), 1);
    tick();
    drain();

    // Youngest producer wins
    issue(3, 1);
    issue(3, 1);
    drive(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    chk("young_fsel0", fsel(0), 1);
    tick();
    drain();

    // r0 destination never allocates, r0 source never forwards
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("r0_fire", sb_if.issue_fire, 1);
    tick();
    chk("r0_inflight", sb_if.inflight, 0);
    drive(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0);
    chk("r0_fsel0", fsel(0), 0);
    chk("r0_fsel1", fsel(1), 0);
    tick();
    drain();

    // Multi-cycle producer, latency 4 and latency 7 (clamped to 4)
    for (int l = 0; l < 2; l++) begin
      issue(9, (l == 0) ? 3'd4 : 3'd7);
      for (int c = 0; c < 3; c++) begin
        drive(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        chk("mul_stall", sb_if.stall, 1);
        tick();
      end
      drive(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0);
      chk("mul_stall_end", sb_if.stall, 0);
      chk("mul_fsel0", fsel(0), 4);
      tick();
      drain();
    end

    // Flush with three entries in flight and an instruction issuing
    issue(1, 1);
    issue(2, 1);
    issue(3, 1);
    chk("fl_inflight3", sb_if.inflight, 3);
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 1);
    chk("fl_fire", sb_if.issue_fire, 0);
    tick();
    chk("fl_inflight0", sb_if.inflight, 0);
    drive(1, 1, 3, 2'b11, 0, 0, 0, 0, 0, 0);
    chk("fl_fsel0", fsel(0), 0);
    chk("fl_fsel1", fsel(1), 0);
    tick();
    drain();

    // Hold freezes entries and remaining latency
    issue(9, 4);
    for (int c = 0; c < 3; c++) begin
      drive(1, 9, 0, 2'b01, 0, 0, 0, 0, 1, 0);
      chk("hold_stall", sb_if.stall, 1);
      chk("hold_fsel0", fsel(0), 1);
      chk("hold_fire", sb_if.issue_fire, 0);
      tick();
      chk("hold_inflight", sb_if.inflight, 1);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0);
      chk("post_hold_stall", sb_if.stall, 1);
      tick();
    end
    drive(0, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    chk("post_hold_fsel0", fsel(0), 4);
    chk("post_hold_inflight", sb_if.inflight, 1);

    // Flush wins over hold
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    chk("flhold_inflight", sb_if.inflight, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
